ssidft_frame_sched: RTL and testbench
=====================================

# ssidft_frame_sched

Frame scheduler for the streaming inverse-DFT accumulator. On each output-sample tick it reads one full N-bin spectrum frame from the ping-pong bin memory written by the SDFT, and streams it as a contiguous sob/eob-framed burst into the inverse accumulator. It owns read address generation, bank selection, read-latency alignment and overrun accounting.

## Interface
- DW, 16, bin component width (re/im)
- N, 2**12, bins per frame (power of two, ≥4)
- AW, $clog2(N), bin address width
- RD_LAT, 2, bin memory read latency in cycles (≥1)
- CW, 16, overrun counter width
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- enable_i  in  1  accept new frame ticks when high
- tick_i  in  1  single-cycle output-sample strobe
- ready_bank_i  in  1  bank index of the last completed SDFT frame
- rd_en_o  out  1  bin memory read strobe
- rd_bank_o  out  1  bank being read
- rd_addr_o  out  AW  bin address
- rd_re_i  in  DW signed  bin real part, RD_LAT cycles after rd_en_o
- rd_im_i  in  DW signed  bin imaginary part, same timing
- sob_o  out  1  first bin of frame
- eob_o  out  1  last bin of frame
- freq_re_o  out  DW signed  bin real part to accumulator
- freq_im_o  out  DW signed  bin imaginary part to accumulator
- busy_o  out  1  frame in progress (state ≠ IDLE)
- overrun_o  out  1  one-cycle pulse on a dropped tick
- overrun_cnt_o  out  CW  saturating count of dropped ticks

## Operation
- FSM states: IDLE, READ, DRAIN.
- IDLE: tick_i & enable_i → latch ready_bank_i into rd_bank_o, addr ← 0, go READ.
- READ: rd_en_o=1 for exactly N cycles, rd_addr_o = 0,1,…,N-1; after addr N-1 go DRAIN.
- DRAIN: wait until eob_o has been issued, then IDLE.
- Sideband pipeline: valid/first/last flags delayed RD_LAT cycles to align with rd_re_i/rd_im_i, then one output register stage. sob_o with bin 0, eob_o with bin N-1, strictly contiguous (no gaps within a frame; downstream accumulator alternates sign on its own counter).
- freq_re_o/freq_im_o = 0 whenever no bin is valid.
- Tick while busy_o=1 → tick dropped, overrun_o pulses, overrun_cnt_o increments, saturating at 2**CW-1. Tick with enable_i=0 → ignored, not an overrun.
- enable_i falling mid-frame: current frame completes; no truncated frames ever.
- rd_bank_o constant for whole frame regardless of ready_bank_i changes.
- Tick coinciding with eob_o cycle: still busy → overrun. Accepted earliest in cycle after eob_o.

## Timing
- Reset: state IDLE, rd_en_o=0, rd_addr_o=0, rd_bank_o=0, sob_o=0, eob_o=0, freq_*_o=0, busy_o=0, overrun_o=0, overrun_cnt_o=0.
- Tick sampled at edge k → rd_en_o high from cycle k+1 for N cycles.
- sob_o at cycle k+1+RD_LAT+1; eob_o N-1 cycles later.
- Tick-to-idle: N+RD_LAT+2 cycles; minimum tick period for zero overruns N+RD_LAT+2.
- Reset mid-frame: immediate abort, all outputs to reset values; system must reset the downstream accumulator together (its counter would otherwise desync).

## Structure
- Shared package ssidft_pkg: FSM state enum, default N/DW constants.
- Sub-module ssidft_sched_dly: RD_LAT-deep flag delay line (valid, first, last), async-reset registers.
- All other logic in ssidft_frame_sched.

## Test plan
- N=8, RD_LAT=2, single tick at cycle 10, bank 1 ready, memory bin i = i+1 → rd_addr 0..7 cycles 11–18, rd_bank_o=1, sob_o at 14 with freq_re_o=1, eob_o at 21 with 8, busy_o low at 22.
- Ticks at cycles 10 and 15 → second dropped, overrun_o pulse at 16, overrun_cnt_o=1, single frame output.
- Ticks every 12 cycles for 20 frames → zero overruns, contiguous 8-cycle sob…eob bursts, bank follows ready_bank_i at each tick.
- enable_i low at cycle 13 mid-frame, tick at 30 → first frame completes fully, tick at 30 ignored, overrun_cnt_o=0.
- CW=2, 5 ticks during one frame → overrun_cnt_o saturates at 3.
- rst_i asserted at cycle 15 mid-frame → all outputs reset values asynchronously; next tick after release produces a full correct frame.

Source files
------------

// File: rtl/ssidft_pkg.sv
// ssidft_pkg: shared scheduler state encoding and default frame geometry.
package ssidft_pkg;
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
    localparam int DEF_N  = 4096;
    localparam int DEF_DW = 16;
endpackage

// File: rtl/ssidft_sched_dly.sv
// ssidft_sched_dly: RD_LAT-deep valid/first/last delay line matching bin memory read latency.
module ssidft_sched_dly #(
    parameter int RD_LAT = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic v_i,
    input  logic f_i,
    input  logic l_i,
    output logic v_o,
    output logic f_o,
    output logic l_o
);
    logic [RD_LAT-1:0][2:0] sr_q, sr_d;

    always_comb begin
        sr_d[0] = {v_i, f_i, l_i};
        for (int i = 1; i < RD_LAT; i++) sr_d[i] = sr_q[i-1];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sr_q <= '0;
        else       sr_q <= sr_d;
    end

    assign {v_o, f_o, l_o} = sr_q[RD_LAT-1];
endmodule

// File: rtl/ssidft_frame_sched.sv
// ssidft_frame_sched: reads one N-bin frame per accepted tick and streams it sob/eob-framed to the inverse accumulator.
module ssidft_frame_sched
    import ssidft_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int N      = DEF_N,
    parameter int AW     = $clog2(N),
    parameter int RD_LAT = 2,
    parameter int CW     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 tick_i,
    input  logic                 ready_bank_i,
    output logic                 rd_en_o,
    output logic                 rd_bank_o,
    output logic [AW-1:0]        rd_addr_o,
    input  logic signed [DW-1:0] rd_re_i,
    input  logic signed [DW-1:0] rd_im_i,
    output logic                 sob_o,
    output logic                 eob_o,
    output logic signed [DW-1:0] freq_re_o,
    output logic signed [DW-1:0] freq_im_o,
    output logic                 busy_o,
    output logic                 overrun_o,
    output logic [CW-1:0]        overrun_cnt_o
);
    state_t state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic bank_q, bank_d, sob_q, sob_d, eob_q, eob_d, ovr_q, ovr_d;
    logic signed [DW-1:0] re_q, re_d, im_q, im_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic dv, df, dl;

    ssidft_sched_dly #(.RD_LAT(RD_LAT)) u_dly (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .v_i   (state_q == READ),
        .f_i   (addr_q == '0),
        .l_i   (addr_q == AW'(N-1)),
        .v_o   (dv),
        .f_o   (df),
        .l_o   (dl)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        bank_d  = bank_q;
        ovr_d   = tick_i & enable_i & (state_q != IDLE);
        cnt_d   = (ovr_d && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        sob_d   = dv & df;
        eob_d   = dv & dl;
        re_d    = dv ? rd_re_i : '0;
        im_d    = dv ? rd_im_i : '0;
        case (state_q)
            IDLE: if (tick_i & enable_i) begin
                state_d = READ;
                bank_d  = ready_bank_i;
                addr_d  = '0;
            end
            // address wraps to 0 after N-1 since N is a power of two
            READ: begin
                addr_d = addr_q + 1'b1;
                if (addr_q == AW'(N-1)) state_d = DRAIN;
            end
            DRAIN: if (eob_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            bank_q  <= 1'b0;
            sob_q   <= 1'b0;
            eob_q   <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            bank_q  <= bank_d;
            sob_q   <= sob_d;
            eob_q   <= eob_d;
            re_q    <= re_d;
            im_q    <= im_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rd_en_o       = state_q == READ;
    assign rd_bank_o     = bank_q;
    assign rd_addr_o     = addr_q;
    assign sob_o         = sob_q;
    assign eob_o         = eob_q;
    assign freq_re_o     = re_q;
    assign freq_im_o     = im_q;
    assign busy_o        = state_q != IDLE;
    assign overrun_o     = ovr_q;
    assign overrun_cnt_o = cnt_q;
endmodule

// File: tb/tb_ssidft_frame_sched.sv
// tb_ssidft_frame_sched: directed cycle-by-cycle check of frame scheduling, overruns, enable gating and reset.
module tb_ssidft_frame_sched;
    localparam int DW = 16, N = 8, AW = 3, RD_LAT = 2, CW = 2, SAT = 3;

    logic clk = 1'b0;
    logic rst, en, tick, rbank, rd_en, rd_bank, sob, eob, busy, ovr;
    logic [AW-1:0] rd_addr;
    logic signed [DW-1:0] rd_re, rd_im, fre, fim;
    logic [CW-1:0] cnt;
    logic signed [DW-1:0] p_re [RD_LAT];
    logic signed [DW-1:0] p_im [RD_LAT];
    int checks = 0, fails = 0, cyc = 0, f0 = -1000, ovr_at = -1000, ecnt = 0;
    logic fb = 1'b0, en_lvl = 1'b1;

    always #5 clk = ~clk;

    ssidft_frame_sched #(.DW(DW), .N(N), .AW(AW), .RD_LAT(RD_LAT), .CW(CW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .enable_i      (en),
        .tick_i        (tick),
        .ready_bank_i  (rbank),
        .rd_en_o       (rd_en),
        .rd_bank_o     (rd_bank),
        .rd_addr_o     (rd_addr),
        .rd_re_i       (rd_re),
        .rd_im_i       (rd_im),
        .sob_o         (sob),
        .eob_o         (eob),
        .freq_re_o     (fre),
        .freq_im_o     (fim),
        .busy_o        (busy),
        .overrun_o     (ovr),
        .overrun_cnt_o (cnt)
    );

    // bin memory: bank b, addr a holds re = 16*b + a + 1, im = -(a + 1); junk when not read
    always @(posedge clk) begin
        p_re[0] <= rd_en ? DW'(int'(rd_bank) * 16 + int'(rd_addr) + 1) : 16'sh7777;
        p_im[0] <= rd_en ? DW'(-(int'(rd_addr) + 1)) : 16'sh5555;
        for (int i = 1; i < RD_LAT; i++) begin
            p_re[i] <= p_re[i-1];
            p_im[i] <= p_im[i-1];
        end
    end
    assign rd_re = p_re[RD_LAT-1];
    assign rd_im = p_im[RD_LAT-1];

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic check_cycle();
        int d;
        bit rv, vv;
        d  = cyc - f0;
        rv = d >= 1 && d <= 8;
        vv = d >= 4 && d <= 11;
        chk("rd_en", int'(rd_en), int'(rv));
        chk("rd_addr", int'(rd_addr), rv ? d - 1 : 0);
        chk("rd_bank", int'(rd_bank), int'(fb));
        chk("sob", int'(sob), int'(d == 4));
        chk("eob", int'(eob), int'(d == 11));
        chk("freq_re", int'(fre), vv ? int'(fb) * 16 + d - 3 : 0);
        chk("freq_im", int'(fim), vv ? 3 - d : 0);
        chk("busy", int'(busy), int'(d >= 1 && d <= 11));
        chk("overrun", int'(ovr), int'(cyc == ovr_at));
        chk("ovr_cnt", int'(cnt), ecnt);
    endtask

    // ex: 0 = no frame expected, 1 = tick accepted, 2 = tick dropped as overrun
    task automatic step(input logic tk, input logic b, input int ex);
        @(negedge clk);
        cyc++;
        check_cycle();
        tick  = tk;
        en    = en_lvl;
        rbank = b;
        if (ex == 1) begin
            f0 = cyc;
            fb = b;
        end
        if (ex == 2) begin
            ovr_at = cyc + 1;
            ecnt   = ecnt < SAT ? ecnt + 1 : SAT;
        end
    endtask

    task automatic idle_until(input int c);
        while (cyc < c - 1) step(1'b0, cyc[0], 0);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; en = 1'b0; rbank = 1'b0;
        repeat (3) @(negedge clk);
        check_cycle();
        rst = 1'b0;
        en  = 1'b1;
        idle_until(10);
        step(1'b1, 1'b1, 1);
        idle_until(40);
        step(1'b1, 1'b0, 1);
        idle_until(45);
        step(1'b1, 1'b1, 2);
        idle_until(60);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, k % 3 == 1, 1);
            idle_until(72 + 12 * k);
        end
        step(1'b1, 1'b1, 1);
        idle_until(311);
        step(1'b1, 1'b0, 2);
        step(1'b1, 1'b0, 1);
        idle_until(340);
        step(1'b1, 1'b1, 1);
        idle_until(343);
        en_lvl = 1'b0;
        idle_until(345);
        step(1'b1, 1'b0, 0);
        idle_until(360);
        step(1'b1, 1'b0, 0);
        idle_until(370);
        en_lvl = 1'b1;
        step(1'b1, 1'b1, 1);
        idle_until(375);
        step(1'b0, 1'b0, 0);
        #2 rst = 1'b1;
        #1;
        f0 = -1000; fb = 1'b0; ecnt = 0; ovr_at = -1000;
        check_cycle();
        step(1'b0, 1'b0, 0);
        rst = 1'b0;
        idle_until(380);
        step(1'b1, 1'b1, 1);
        idle_until(400);
        step(1'b1, 1'b0, 1);
        for (int j = 0; j < 5; j++) step(1'b1, 1'b1, 2);
        idle_until(420);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
